// File: rtl/adder_op_sequencer.sv
// adder_op_sequencer: handshake-driven sequencer around an external W-bit
// combinational adder. Narrow ops take one pass through the adder, wide ops
// take two (low half, then high half fed with the low half's carry-out).
// Subtraction inverts B and forces carry-in to 1.
// Optional feature macro: ADD_SAT_EN -- saturate the result on signed overflow.
module adder_op_sequencer #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_op_a,
  input  logic [2*W-1:0] in_op_b,
  input  logic           in_cin,
  input  logic           in_sub,
  input  logic           in_wide,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_cin,
  input  logic [W-1:0]   add_sum,
  input  logic           add_cout,
  input  logic           add_ovf,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_result,
  output logic           out_cout,
  output logic           out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [2*W-1:0] a_reg;
  logic [2*W-1:0] b_reg;
  logic [2*W-1:0] res_reg;
  logic           c0_reg;
  logic           wide_reg;
  logic           c_reg;
  logic           cout_reg;
  logic           ovf_reg;
  logic           accept;

`ifdef ADD_SAT_EN
  // Saturation targets; direction follows the sign of operand A.
  logic [W-1:0]   sat_narrow;
  logic [2*W-1:0] sat_wide;
  assign sat_narrow = a_reg[W-1]   ? {1'b1, {(W-1){1'b0}}}   : {1'b0, {(W-1){1'b1}}};
  assign sat_wide   = a_reg[2*W-1] ? {1'b1, {(2*W-1){1'b0}}} : {1'b0, {(2*W-1){1'b1}}};
`endif

  // Input handshake: free when idle, or when the held result retires this cycle.
  always_comb begin
    in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    accept   = in_valid && in_ready;
  end

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: every combinationally assigned signal gets a default first so no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LO;
      LO:      state_nxt = wide_reg ? HI : DONE;
      HI:      state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = LO;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Adder drive and output valid, decoded from the current state.
  always_comb begin
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    out_valid = (state == DONE);
    case (state)
      LO: begin
        add_a   = a_reg[W-1:0];
        add_b   = b_reg[W-1:0];
        add_cin = c0_reg;
      end
      HI: begin
        add_a   = a_reg[2*W-1:W];
        add_b   = b_reg[2*W-1:W];
        add_cin = c_reg;
      end
      default: ;
    endcase
  end

  // Operand capture on accept and result capture at the end of each pass.
  // NOTE: these are plain registers, not a memory array, so all of them are
  // reset; a reset mid-op therefore leaves no stale operand or result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      c0_reg   <= 1'b0;
      wide_reg <= 1'b0;
      c_reg    <= 1'b0;
      res_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      if (accept) begin
        a_reg    <= in_op_a;
        b_reg    <= in_sub ? ~in_op_b : in_op_b;
        c0_reg   <= in_sub ? 1'b1 : in_cin;
        wide_reg <= in_wide;
      end
      case (state)
        LO: begin
          res_reg[W-1:0] <= add_sum;
          c_reg          <= add_cout;
          if (!wide_reg) begin
            cout_reg <= add_cout;
            ovf_reg  <= add_ovf;
            res_reg[2*W-1:W] <= '0;
`ifdef ADD_SAT_EN
            if (add_ovf) res_reg[W-1:0] <= sat_narrow;
`endif
          end
        end
        HI: begin
          res_reg[2*W-1:W] <= add_sum;
          cout_reg         <= add_cout;
          ovf_reg          <= add_ovf;
`ifdef ADD_SAT_EN
          if (add_ovf) res_reg <= sat_wide;
`endif
        end
        default: ;
      endcase
    end
  end

  assign out_result = res_reg;
  assign out_cout   = cout_reg;
  assign out_ovf    = ovf_reg;

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Bench for adder_op_sequencer. The external adder is modelled as plain
// W-bit arithmetic; results are predicted by a wide-integer reference model.
// Honours ADD_SAT_EN the same way the design does.
module tb_adder_op_sequencer;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] in_op_a;
  logic [2*W-1:0] in_op_b;
  logic           in_cin;
  logic           in_sub;
  logic           in_wide;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;
  logic           add_ovf;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_result;
  logic           out_cout;
  logic           out_ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adder_op_sequencer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op_a(in_op_a), .in_op_b(in_op_b),
    .in_cin(in_cin), .in_sub(in_sub), .in_wide(in_wide),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_ovf(add_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // Attached combinational adder.
  always_comb begin
    {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    add_ovf = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
  end

  // Reference: whole-width unsigned and signed arithmetic on the effective width.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub, input logic wide,
                                output logic [63:0] res, output logic cout,
                                output logic ovf);
    logic [65:0]        m, ua, ub, us;
    logic signed [65:0] sa, sb, ss, smax, smin;
    logic               c;
    int                 w;
    w  = wide ? 64 : 32;
    m  = wide ? 66'h0_FFFF_FFFF_FFFF_FFFF : 66'h0_0000_0000_FFFF_FFFF;
    c  = sub ? 1'b1 : cin;
    ua = {2'b00, a} & m;
    ub = (sub ? ~{2'b00, b} : {2'b00, b}) & m;
    us = ua + ub + {65'd0, c};
    cout = us[w];
    res  = us[63:0] & m[63:0];
    sa = wide ? {{2{ua[63]}}, ua[63:0]} : {{34{ua[31]}}, ua[31:0]};
    sb = wide ? {{2{ub[63]}}, ub[63:0]} : {{34{ub[31]}}, ub[31:0]};
    ss = sa + sb + {65'd0, c};
    smax = (66'sd1 <<< (w - 1)) - 66'sd1;
    smin = -(66'sd1 <<< (w - 1));
    ovf  = (ss > smax) || (ss < smin);
`ifdef ADD_SAT_EN
    if (ovf) res = (wide ? a[63] : a[31]) ? (smin[63:0] & m[63:0]) : smax[63:0];
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op_a = '0; in_op_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_wide = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // One transaction with explicit expectations; optional junk on in_* while busy.
  task automatic run_op_exp(input string name, input logic [63:0] a, input logic [63:0] b,
                            input logic cin, input logic sub, input logic wide,
                            input logic [63:0] er, input logic ec, input logic eo,
                            input bit junk);
    int lat;
    int waits;
    in_op_a = a; in_op_b = b; in_cin = cin; in_sub = sub; in_wide = wide;
    in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 20) begin step(); waits++; end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
      in_valid = 1'b0;
      return;
    end
    step();
    lat = 1;
    in_valid = junk;
    if (junk) begin
      in_op_a = {$urandom, $urandom}; in_op_b = {$urandom, $urandom};
      in_cin = 1'($urandom); in_sub = 1'($urandom); in_wide = 1'($urandom);
    end
    while (!out_valid && lat < 8) begin
      step();
      lat++;
      if (junk) begin
        in_op_a = {$urandom, $urandom}; in_op_b = {$urandom, $urandom};
      end
    end
    in_valid = 1'b0;
    tests++;
    if (lat != (wide ? 3 : 2)) begin
      fails++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, wide ? 3 : 2);
    end
    tests++;
    if ({out_result, out_cout, out_ovf} !== {er, ec, eo}) begin
      fails++;
      $display("FAIL %s result: got %h c=%b v=%b required %h c=%b v=%b",
               name, out_result, out_cout, out_ovf, er, ec, eo);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s retire: out_valid=%b required 0", name, out_valid);
    end
  endtask

  task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, input logic wide, input bit junk);
    logic [63:0] er;
    logic        ec, eo;
    model(a, b, cin, sub, wide, er, ec, eo);
    run_op_exp(name, a, b, cin, sub, wide, er, ec, eo, junk);
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({out_valid, in_ready, out_cout, out_ovf} !== 4'b0100 || out_result !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b ready=%b c=%b v=%b res=%h required 0 1 0 0 0",
               out_valid, in_ready, out_cout, out_ovf, out_result);
    end
    tests++;
    if ({add_a, add_b, add_cin} !== '0) begin
      fails++;
      $display("FAIL reset_adder_drive: a=%h b=%h cin=%b required zeros", add_a, add_b, add_cin);
    end
  endtask

  task automatic test_directed();
    logic [63:0] r4;
    logic [63:0] r5;
`ifdef ADD_SAT_EN
    r4 = 64'h0000_0000_7FFF_FFFF;
    r5 = 64'h8000_0000_0000_0000;
`else
    r4 = 64'h0000_0000_8000_0000;
    r5 = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    run_op_exp("narrow_add", 64'h5, 64'h3, 1'b1, 1'b0, 1'b0, 64'h9, 1'b0, 1'b0, 1'b0);
    run_op_exp("narrow_sub", 64'h3, 64'h5, 1'b0, 1'b1, 1'b0,
               64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op_exp("wide_carry", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1,
               64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    run_op_exp("narrow_ovf", 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, r4, 1'b0, 1'b1, 1'b0);
    run_op_exp("wide_sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 1'b1,
               r5, 1'b1, 1'b1, 1'b0);
    run_op_exp("narrow_upper_ignored", 64'hDEAD_BEEF_0000_0010, 64'hCAFE_F00D_0000_0020,
               1'b0, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 8 == 0) a[62:0] = '1;
      if (i % 8 == 4) a[30:0] = '1;
      run_op("random", a, b, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] er1, er2, a2, b2, hold;
    logic        ec, eo;
    model(64'd10, 64'd20, 1'b0, 1'b0, 1'b0, er1, ec, eo);
    a2 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    model(a2, b2, 1'b1, 1'b0, 1'b0, er2, ec, eo);
    in_op_a = 64'd10; in_op_b = 64'd20; in_cin = 1'b0; in_sub = 1'b0; in_wide = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    hold = out_result;
    tests++;
    if (out_valid !== 1'b1 || hold !== er1) begin
      fails++;
      $display("FAIL bp_first: valid=%b res=%h required 1 %h", out_valid, hold, er1);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== er1) begin
        fails++;
        $display("FAIL bp_hold: valid=%b ready=%b res=%h required 1 0 %h",
                 out_valid, in_ready, out_result, er1);
      end
    end
    in_op_a = a2; in_op_b = b2; in_cin = 1'b1; in_sub = 1'b0; in_wide = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || add_a !== a2[31:0] || add_cin !== 1'b1) begin
      fails++;
      $display("FAIL b2b_lo: valid=%b add_a=%h cin=%b required 0 %h 1",
               out_valid, add_a, add_cin, a2[31:0]);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_result !== er2) begin
      fails++;
      $display("FAIL b2b_result: valid=%b res=%h required 1 %h", out_valid, out_result, er2);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] a;
    a = 64'h1234_5678_FFFF_FFFF;
    in_op_a = a; in_op_b = 64'h1; in_cin = 1'b0; in_sub = 1'b0; in_wide = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    tests++;
    if (add_a !== a[63:32] || add_b !== 32'h0 || add_cin !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL hi_drive: a=%h b=%h cin=%b valid=%b required %h 0 1 0",
               add_a, add_b, add_cin, out_valid, a[63:32]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== '0 ||
        {add_a, add_b, add_cin} !== '0) begin
      fails++;
      $display("FAIL async_reset: valid=%b ready=%b res=%h add_a=%h required 0 1 0 0",
               out_valid, in_ready, out_result, add_a);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL post_reset_idle: ready=%b valid=%b required 1 0", in_ready, out_valid);
      end
    end
    run_op("after_reset", 64'h0000_0000_0000_0007, 64'h0000_0000_0000_0002,
           1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
